// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and constants for the 16-bit CPU control path.
//   state_e : sequencer state encoding (3 bits, also exported for debug)
//   OP_*    : opcode field values (instruction[15:12])
//   is_alu  : true for the opcodes that go through the ALU and write back
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_MEM       = 3'd4,
    ST_WRITEBACK = 3'd5,
    ST_HALTED    = 3'd6
  } state_e;

  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_LOAD   = 4'h1;
  localparam logic [3:0] OP_JUMP   = 4'h2;
  localparam logic [3:0] OP_BRANCH = 4'h3;
  localparam logic [3:0] OP_ALU_A  = 4'h4;
  localparam logic [3:0] OP_ALU_B  = 4'h8;
  localparam logic [3:0] OP_HALT   = 4'hF;

  function automatic logic is_alu(input logic [3:0] op);
    return (op == OP_ALU_A) || (op == OP_ALU_B);
  endfunction

endpackage

// File: rtl/cpu_sequencer_wait_counter.sv
// wait_counter: 4-bit RAM wait-state counter shared by FETCH and MEM.
//   clk, rst : clock, asynchronous active-high reset
//   clear    : reload the count to 0 (state entry)
//   en       : advance while the access is in progress
//   limit    : number of extra wait cycles (MEM_WAIT)
//   done     : final cycle of the access (count has reached limit)
// The count holds elapsed wait cycles, so an access lasts limit+1 cycles
// and the register reads 0 at the start of every access.
module wait_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       en,
  input  logic [3:0] limit,
  output logic       done
);

  logic [3:0] cnt_q, cnt_d;

  assign done = (cnt_q == limit);

  always_comb begin
    cnt_d = cnt_q;
    if (clear)             cnt_d = '0;
    else if (en && !done)  cnt_d = cnt_q + 4'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle fetch/decode/execute controller.
//   clk, reset    : clock, asynchronous active-high reset
//   run, halt_req : start/resume level, stop-at-boundary level
//   instruction   : RAM instruction data (opcode in [15:12])
//   branch_taken  : ALU branch condition, used in EXECUTE
//   ir_load, pc_inc, pc_load, ram_read, reg_read, reg_write, alu_en : enables
//   busy, halted, state : status / debug
//   retired       : retired-instruction count (wraps)
// Every output is decoded from registered state (plus branch_taken), so
// reset forces all enables low immediately without waiting for an edge.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int MEM_WAIT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        halt_req,
  input  logic [15:0] instruction,
  input  logic        branch_taken,
  output logic        ir_load,
  output logic        pc_inc,
  output logic        pc_load,
  output logic        ram_read,
  output logic        reg_read,
  output logic        reg_write,
  output logic        alu_en,
  output logic        busy,
  output logic        halted,
  output logic [2:0]  state,
  output logic [15:0] retired
);

  localparam logic [3:0] WAIT_LIMIT = 4'(MEM_WAIT);

  state_e      state_q, state_d;
  logic [3:0]  opcode_q, opcode_d;
  logic [15:0] retired_q, retired_d;
  logic        retire;
  logic        wc_done;
  logic        unused_instr_bits;

  assign unused_instr_bits = ^instruction[11:0];

  // Clearing on every state change guarantees a fresh count on entry to
  // FETCH and MEM, including back-to-back FETCHes after a retire.
  wait_counter u_wait (
    .clk   (clk),
    .rst   (reset),
    .clear (state_d != state_q),
    .en    ((state_q == ST_FETCH) || (state_q == ST_MEM)),
    .limit (WAIT_LIMIT),
    .done  (wc_done)
  );

  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    retired_d = retired_q;
    retire    = 1'b0;
    ir_load   = 1'b0;
    pc_inc    = 1'b0;
    pc_load   = 1'b0;
    ram_read  = 1'b0;
    reg_read  = 1'b0;
    reg_write = 1'b0;
    alu_en    = 1'b0;

    case (state_q)
      ST_IDLE: if (run) state_d = ST_FETCH;

      ST_FETCH: if (wc_done) begin
        ir_load  = 1'b1;
        opcode_d = instruction[15:12];
        state_d  = ST_DECODE;
      end

      ST_DECODE: begin
        reg_read = 1'b1;
        state_d  = ST_EXECUTE;
      end

      ST_EXECUTE: begin
        alu_en   = 1'b1;
        reg_read = 1'b1;
        if (is_alu(opcode_q))           state_d = ST_WRITEBACK;
        else if (opcode_q == OP_LOAD)   state_d = ST_MEM;
        else begin
          retire = 1'b1;
          case (opcode_q)
            OP_JUMP:   pc_load = 1'b1;
            OP_BRANCH: begin
              pc_load = branch_taken;
              pc_inc  = !branch_taken;
            end
            OP_HALT:   ;  // PC stays on the HALT instruction
            default:   pc_inc = 1'b1;
          endcase
        end
      end

      ST_MEM: begin
        ram_read = 1'b1;
        if (wc_done) state_d = ST_WRITEBACK;
      end

      ST_WRITEBACK: begin
        reg_write = 1'b1;
        pc_inc    = 1'b1;
        retire    = 1'b1;
      end

      ST_HALTED: if (run && !halt_req) state_d = ST_FETCH;

      default: state_d = ST_IDLE;
    endcase

    // halt_req only matters at an instruction boundary.
    if (retire) begin
      retired_d = retired_q + 16'd1;
      state_d   = (halt_req || (opcode_q == OP_HALT)) ? ST_HALTED : ST_FETCH;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      opcode_q  <= OP_NOP;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      retired_q <= retired_d;
    end
  end

  assign busy    = (state_q != ST_IDLE) && (state_q != ST_HALTED);
  assign halted  = (state_q == ST_HALTED);
  assign state   = state_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
module tb_cpu_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic halt_req = 1'b0;
  logic branch_taken = 1'b0;
  always #5 clk = ~clk;

  // dut0: MEM_WAIT=0
  logic        run0 = 1'b0;
  logic [15:0] instr0 = '0;
  logic        ir0, inc0, ld0, ram0, rr0, rw0, alu0, busy0, hlt0;
  logic [2:0]  st0;
  logic [15:0] ret0;

  // dut2: MEM_WAIT=2
  logic        run2 = 1'b0;
  logic [15:0] instr2 = '0;
  logic        ir2, inc2, ld2, ram2, rr2, rw2, alu2, busy2, hlt2;
  logic [2:0]  st2;
  logic [15:0] ret2;

  cpu_sequencer #(.MEM_WAIT(0)) dut0 (
    .clk(clk), .reset(rst), .run(run0), .halt_req(halt_req),
    .instruction(instr0), .branch_taken(branch_taken),
    .ir_load(ir0), .pc_inc(inc0), .pc_load(ld0), .ram_read(ram0),
    .reg_read(rr0), .reg_write(rw0), .alu_en(alu0), .busy(busy0),
    .halted(hlt0), .state(st0), .retired(ret0)
  );

  cpu_sequencer #(.MEM_WAIT(2)) dut2 (
    .clk(clk), .reset(rst), .run(run2), .halt_req(halt_req),
    .instruction(instr2), .branch_taken(branch_taken),
    .ir_load(ir2), .pc_inc(inc2), .pc_load(ld2), .ram_read(ram2),
    .reg_read(rr2), .reg_write(rw2), .alu_en(alu2), .busy(busy2),
    .halted(hlt2), .state(st2), .retired(ret2)
  );

  // output vector order: {ir_load,pc_inc,pc_load,ram_read,reg_read,reg_write,alu_en,busy,halted}
  localparam logic [8:0] O_IR = 9'h100, O_INC = 9'h080, O_LD = 9'h040, O_RAM = 9'h020,
                         O_RR = 9'h010, O_RW  = 9'h008, O_ALU = 9'h004, O_BSY = 9'h002,
                         O_HLT = 9'h001;

  typedef struct packed {
    logic        run;
    logic        hreq;
    logic [3:0]  op;
    logic        br;
    logic [8:0]  eo;
    logic [2:0]  es;
    logic [15:0] er;
  } vec_t;

  int checks = 0;
  int failures = 0;

  function automatic vec_t v(input logic r, input logic h, input logic [3:0] op,
                             input logic b, input logic [8:0] eo,
                             input logic [2:0] es, input logic [15:0] er);
    vec_t t;
    t.run = r; t.hreq = h; t.op = op; t.br = b; t.eo = eo; t.es = es; t.er = er;
    return t;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s idx=%0d got=%h exp=%h", name, idx, got, exp);
    end
  endtask

  function automatic logic [8:0] outs0();
    return {ir0, inc0, ld0, ram0, rr0, rw0, alu0, busy0, hlt0};
  endfunction

  vec_t tbl[30];
  int   es2[11];
  logic [10:0] m_ir, m_ram, m_rw;
  bit   found;

  initial begin
    // ALU, BRANCH taken/not, JUMP, HALT + restart, halt_req mid-ALU, run+halt_req in HALTED, other->NOP
    tbl[0]  = v(1,0,4'h0,0, 9'h000,             3'd0, 16'd0);
    tbl[1]  = v(0,0,4'h8,0, O_IR|O_BSY,         3'd1, 16'd0);
    tbl[2]  = v(0,0,4'h8,0, O_RR|O_BSY,         3'd2, 16'd0);
    tbl[3]  = v(0,0,4'h8,0, O_RR|O_ALU|O_BSY,   3'd3, 16'd0);
    tbl[4]  = v(0,0,4'h8,0, O_RW|O_INC|O_BSY,   3'd5, 16'd0);
    tbl[5]  = v(0,0,4'h3,1, O_IR|O_BSY,         3'd1, 16'd1);
    tbl[6]  = v(0,0,4'h3,1, O_RR|O_BSY,         3'd2, 16'd1);
    tbl[7]  = v(0,0,4'h3,1, O_RR|O_ALU|O_LD|O_BSY, 3'd3, 16'd1);
    tbl[8]  = v(0,0,4'h3,0, O_IR|O_BSY,         3'd1, 16'd2);
    tbl[9]  = v(0,0,4'h3,0, O_RR|O_BSY,         3'd2, 16'd2);
    tbl[10] = v(0,0,4'h3,0, O_RR|O_ALU|O_INC|O_BSY, 3'd3, 16'd2);
    tbl[11] = v(0,0,4'h2,0, O_IR|O_BSY,         3'd1, 16'd3);
    tbl[12] = v(0,0,4'h2,0, O_RR|O_BSY,         3'd2, 16'd3);
    tbl[13] = v(0,0,4'h2,0, O_RR|O_ALU|O_LD|O_BSY, 3'd3, 16'd3);
    tbl[14] = v(0,0,4'hF,0, O_IR|O_BSY,         3'd1, 16'd4);
    tbl[15] = v(0,0,4'hF,0, O_RR|O_BSY,         3'd2, 16'd4);
    tbl[16] = v(1,0,4'hF,0, O_RR|O_ALU|O_BSY,   3'd3, 16'd4);
    tbl[17] = v(1,0,4'h8,0, O_HLT,              3'd6, 16'd5);
    tbl[18] = v(0,0,4'h8,0, O_IR|O_BSY,         3'd1, 16'd5);
    tbl[19] = v(0,1,4'h8,0, O_RR|O_BSY,         3'd2, 16'd5);
    tbl[20] = v(0,1,4'h8,0, O_RR|O_ALU|O_BSY,   3'd3, 16'd5);
    tbl[21] = v(0,1,4'h8,0, O_RW|O_INC|O_BSY,   3'd5, 16'd5);
    tbl[22] = v(1,1,4'h8,0, O_HLT,              3'd6, 16'd6);
    tbl[23] = v(1,1,4'h8,0, O_HLT,              3'd6, 16'd6);
    tbl[24] = v(0,0,4'h8,0, O_HLT,              3'd6, 16'd6);
    tbl[25] = v(1,0,4'h5,0, O_HLT,              3'd6, 16'd6);
    tbl[26] = v(0,0,4'h5,0, O_IR|O_BSY,         3'd1, 16'd6);
    tbl[27] = v(0,0,4'h5,0, O_RR|O_BSY,         3'd2, 16'd6);
    tbl[28] = v(0,0,4'h5,0, O_RR|O_ALU|O_INC|O_BSY, 3'd3, 16'd6);
    tbl[29] = v(0,0,4'h0,0, O_IR|O_BSY,         3'd1, 16'd7);

    // LOAD with MEM_WAIT=2, cycle 0 = IDLE with run
    es2 = '{0, 1, 1, 1, 2, 3, 4, 4, 4, 5, 1};
    m_ir  = 11'b00000001000;
    m_ram = 11'b00111000000;
    m_rw  = 11'b01000000000;

    // reset state
    #3;
    chk("reset0", 0, {3'd0, outs0(), st0, ret0}, 32'd0);
    chk("reset2", 0, {3'd0, ir2, inc2, ld2, ram2, rr2, rw2, alu2, busy2, hlt2, st2, ret2}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // table-driven sequence on dut0
    for (int i = 0; i < 30; i++) begin
      if (i != 0) @(negedge clk);
      run0 = tbl[i].run;
      halt_req = tbl[i].hreq;
      instr0 = {tbl[i].op, 12'h000};
      branch_taken = tbl[i].br;
      #1;
      chk("vec", i, {3'd0, outs0(), st0, ret0}, {3'd0, tbl[i].eo, tbl[i].es, tbl[i].er});
    end
    run0 = 1'b0;
    halt_req = 1'b0;
    branch_taken = 1'b0;

    // LOAD timing with wait states
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      run2 = (c == 0);
      instr2 = 16'h1000;
      #1;
      chk("load_state", c, {29'd0, st2}, es2[c]);
      chk("load_en", c, {29'd0, ir2, ram2, rw2}, {29'd0, m_ir[c], m_ram[c], m_rw[c]});
    end
    chk("load_retired", 0, {16'd0, ret2}, 32'd1);

    // async reset in MEM with retired=0x1234
    @(negedge clk);
    rst = 1'b1;
    #2;
    @(negedge clk);
    rst = 1'b0;
    run0 = 1'b1;
    instr0 = 16'h0000;
    found = 1'b0;
    for (int n = 0; n < 20000 && !found; n++) begin
      @(negedge clk);
      #1;
      if (ret0 == 16'h1234) found = 1'b1;
    end
    chk("reach_1234", 0, {31'd0, found}, 32'd1);
    instr0 = 16'h1000;
    run0 = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("in_mem", 0, {12'd0, ram0, st0, ret0}, {12'd0, 1'b1, 3'd4, 16'h1234});
    #1;
    rst = 1'b1;
    #1;
    chk("async_reset", 0, {3'd0, outs0(), st0, ret0}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // retired wrap 0xFFFF -> 0x0000
    force dut0.retired_q = 16'hFFFF;
    #1;
    release dut0.retired_q;
    run0 = 1'b1;
    instr0 = 16'h0000;
    repeat (3) @(negedge clk);
    #1;
    chk("pre_wrap", 0, {13'd0, st0, ret0}, {13'd0, 3'd3, 16'hFFFF});
    @(negedge clk);
    #1;
    chk("wrap", 0, {13'd0, st0, ret0}, {13'd0, 3'd1, 16'h0000});
    run0 = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
